// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median stream filter.
package median_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MED_LAT = 3;

endpackage

// File: rtl/median9_sort.sv
// Exact median of nine unsigned values, three registered stages.
// Stage 1 sorts each triple, stage 2 reduces to the anti-diagonal, stage 3 takes its median.
module median9_sort #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    valid,
  input  logic [9*DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out
);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  function automatic pix_t f_min(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t f_max(input pix_t a, input pix_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic pix_t f_med3(input pix_t a, input pix_t b, input pix_t c);
    return f_max(f_min(a, b), f_min(f_max(a, b), c));
  endfunction

  pix_t w_pix [9];
  pix_t r_lo  [3];
  pix_t r_mid [3];
  pix_t r_hi  [3];
  pix_t r_a, r_b, r_c;
  logic r_v1, r_v2;

  always_comb begin
    for (int i = 0; i < 9; i++) w_pix[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (en) begin
      r_v1      <= valid;
      r_v2      <= r_v1;
      valid_out <= r_v2;
      if (r_v2) data_out <= f_med3(r_a, r_b, r_c);
    end
  end

  // data stages only load behind a valid tag so bubbles leave the last result in place
  always_ff @(posedge clk) begin
    if (!reset && en) begin
      if (valid) begin
        for (int k = 0; k < 3; k++) begin
          r_lo[k]  <= f_min(f_min(w_pix[3*k], w_pix[3*k+1]), w_pix[3*k+2]);
          r_mid[k] <= f_med3(w_pix[3*k], w_pix[3*k+1], w_pix[3*k+2]);
          r_hi[k]  <= f_max(f_max(w_pix[3*k], w_pix[3*k+1]), w_pix[3*k+2]);
        end
      end
      if (r_v1) begin
        r_a <= f_max(f_max(r_lo[0], r_lo[1]), r_lo[2]);
        r_b <= f_med3(r_mid[0], r_mid[1], r_mid[2]);
        r_c <= f_min(f_min(r_hi[0], r_hi[1]), r_hi[2]);
      end
    end
  end

endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter over raster frames; interior pixels only.
// Optional SOF_OUT/EOF_OUT frame flags when MEDIAN_FRAME_FLAGS_EN is defined.
module median3x3_stream
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  Valid_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
`ifdef MEDIAN_FRAME_FLAGS_EN
  output logic                  SOF_OUT,
  output logic                  EOF_OUT,
`endif
  output logic                  Valid_OUT
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_line1 [IMG_W];
  logic [DATA_WIDTH-1:0] r_line2 [IMG_W];
  logic [DATA_WIDTH-1:0] r_win   [9];
  logic                  r_win_valid;
  logic                  w_accept;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [9*DATA_WIDTH-1:0] w_win_flat;

  assign w_accept   = en & Valid_IN;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_state     <= FILL;
      r_win_valid <= 1'b0;
    end else if (en) begin
      r_win_valid <= w_accept && (r_state == ACTIVE) && (r_col >= COL_TWO);
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            r_row   <= '0;
            r_state <= FILL;
          end else begin
            r_row <= r_row + RW'(1);
            if (r_row == ROW_ONE) r_state <= ACTIVE;
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // window columns are {top, mid, bottom}; index 0..2 is the oldest column
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_line1[r_col] <= DATA_IN;
      r_line2[r_col] <= r_line1[r_col];
      for (int i = 0; i < 6; i++) r_win[i] <= r_win[i+3];
      r_win[6] <= r_line2[r_col];
      r_win[7] <= r_line1[r_col];
      r_win[8] <= DATA_IN;
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) w_win_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_win[i];
  end

  median9_sort #(.DATA_WIDTH(DATA_WIDTH)) u_sort (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .valid    (r_win_valid),
    .data_in  (w_win_flat),
    .data_out (DATA_OUT),
    .valid_out(Valid_OUT)
  );

`ifdef MEDIAN_FRAME_FLAGS_EN
  logic       r_win_sof, r_win_eof;
  logic [1:0] r_sof_pipe, r_eof_pipe;

  // flags ride alongside the sorter so they line up with Valid_OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_sof  <= 1'b0;
      r_win_eof  <= 1'b0;
      r_sof_pipe <= '0;
      r_eof_pipe <= '0;
      SOF_OUT    <= 1'b0;
      EOF_OUT    <= 1'b0;
    end else if (en) begin
      r_win_sof  <= w_accept && (r_row == ROW_TWO) && (r_col == COL_TWO);
      r_win_eof  <= w_accept && w_row_last && w_col_last;
      r_sof_pipe <= {r_sof_pipe[0], r_win_sof};
      r_eof_pipe <= {r_eof_pipe[0], r_win_eof};
      SOF_OUT    <= r_sof_pipe[1];
      EOF_OUT    <= r_eof_pipe[1];
    end
  end
`endif

endmodule

// File: tb/tb_median3x3_stream.sv
// Scoreboard bench for median3x3_stream on a small 8x6 frame.
// Connects and checks SOF_OUT/EOF_OUT when MEDIAN_FRAME_FLAGS_EN is defined.
module tb_median3x3_stream;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          Valid_IN = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic [DW-1:0] DATA_OUT;
  logic          Valid_OUT;
`ifdef MEDIAN_FRAME_FLAGS_EN
  logic          SOF_OUT, EOF_OUT;
`endif

  median3x3_stream #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .Valid_IN (Valid_IN),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
`ifdef MEDIAN_FRAME_FLAGS_EN
    .SOF_OUT  (SOF_OUT),
    .EOF_OUT  (EOF_OUT),
`endif
    .Valid_OUT(Valid_OUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
    bit            sof;
    bit            eof;
  } exp_t;

  exp_t          sbq[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_out = 0;
  int            en_cyc = 0;
  bit            edge_en = 1'b0;
  int            m_col = 0;
  int            m_row = 0;
  logic [DW-1:0] img [H][W];

  always @(posedge clk) begin
    edge_en = en && !reset;
    if (en) en_cyc++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (edge_en && Valid_OUT) begin
      n_out++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got data=%02h at cycle %0d, required no output", DATA_OUT, en_cyc);
      end else begin
        e = sbq.pop_front();
        if (DATA_OUT !== e.data || en_cyc != e.stamp
`ifdef MEDIAN_FRAME_FLAGS_EN
            || SOF_OUT !== e.sof || EOF_OUT !== e.eof
`endif
           ) begin
          n_err++;
          $display("FAIL out#%0d: got data=%02h cycle=%0d, required data=%02h cycle=%0d sof=%0b eof=%0b",
                   n_out, DATA_OUT, en_cyc, e.data, e.stamp, e.sof, e.eof);
        end
      end
    end
  end

  function automatic logic [DW-1:0] ref_median(input int r, input int c);
    logic [DW-1:0] v [9];
    logic [DW-1:0] t;
    int k = 0;
    for (int i = r - 2; i <= r; i++)
      for (int j = c - 2; j <= c; j++) begin
        v[k] = img[i][j];
        k++;
      end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[4];
  endfunction

  function automatic logic [DW-1:0] pix_of(input int pat, input int r, input int c);
    case (pat)
      0: return 8'h55;
      1: return (r == 3 && c == 3) ? 8'hFF : 8'h00;
      2: return DW'(c);
      3: return 8'h20;
      default: return DW'(((r * 7 + c * 3) % 5) * 'h33);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic drive_pix(input logic [DW-1:0] px, input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    en       = 1'b1;
    Valid_IN = v;
    DATA_IN  = v ? px : 8'hA5;
    if (v) begin
      img[m_row][m_col] = px;
      if (m_row >= 2 && m_col >= 2) begin
        e.data  = ref_median(m_row, m_col);
        e.stamp = en_cyc + 1 + 3;
        e.sof   = (m_row == 2 && m_col == 2);
        e.eof   = (m_row == H - 1 && m_col == W - 1);
        sbq.push_back(e);
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      en       = 1'b0;
      Valid_IN = 1'b1;
      DATA_IN  = 8'h77;
    end
  endtask

  task automatic send_frame(input int pat, input bit bubbles, input int stall_r, input int stall_c,
                            input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (bubbles) drive_pix(8'h00, 1'b0);
        if (r == stall_r && c == stall_c) stall(10);
        drive_pix(pix_of(pat, r, c), 1'b1);
      end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sbq.size() != 0 && k < 20) begin
      drive_pix(8'h00, 1'b0);
      k++;
    end
    repeat (4) drive_pix(8'h00, 1'b0);
    check({name, "_drained"}, sbq.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    sbq.delete();
    reset    = 1'b1;
    Valid_IN = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    m_col = 0;
    m_row = 0;
    check("reset_valid_out", Valid_OUT, 1'b0);
    check("reset_data_out", DATA_OUT, 8'h00);
  endtask

  initial begin
    int base;
    // en held low through reset: reset must still take effect
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_valid_out", Valid_OUT, 1'b0);
    check("init_data_out", DATA_OUT, 8'h00);
    reset = 1'b0;

    base = n_out;
    send_frame(0, 1'b0, -1, -1, -1, -1);
    drain("const55");
    check("const55_count", n_out - base, 24);

    base = n_out;
    send_frame(1, 1'b0, -1, -1, -1, -1);
    drain("impulse");
    check("impulse_count", n_out - base, 24);

    base = n_out;
    send_frame(2, 1'b0, -1, -1, -1, -1);
    drain("ramp");
    check("ramp_count", n_out - base, 24);

    base = n_out;
    send_frame(2, 1'b1, 3, 4, -1, -1);
    drain("ramp_bubble_stall");
    check("ramp_bubble_stall_count", n_out - base, 24);

    base = n_out;
    send_frame(4, 1'b0, -1, -1, -1, -1);
    send_frame(2, 1'b0, -1, -1, -1, -1);
    drain("two_frames");
    check("two_frames_count", n_out - base, 48);

    send_frame(2, 1'b0, -1, -1, 4, 3);
    do_reset(2);
    base = n_out;
    send_frame(3, 1'b0, -1, -1, -1, -1);
    drain("after_reset");
    check("after_reset_count", n_out - base, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
